prgrm_counter_stk: RTL and testbench

- Parametrised next-generation program counter for the GPU core's fetch stage.
- Generalises address width and reset vector, and adds fetch stall, call/return through an internal hardware return-address stack, and halt/resume.
- Drives the instruction-memory address each cycle. Reports stack depth and sticky stack-error flags to the control/debug logic.

---
 rtl/prgrm_counter_stk.sv | 110 +++++++++++
 tb/tb_prgrm_counter_stk.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prgrm_counter_stk.sv
// Fetch-stage program counter with a hardware return-address stack,
// fetch stall and halt/resume control.
module prgrm_counter_stk #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    localparam int               PTR_W       = $clog2(STACK_DEPTH),
    localparam int               LVL_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              is_jmp,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              pc_valid,
    output logic              halted,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] stk [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_inc;
    logic [LVL_W-1:0]  lvl_m1;
    logic              stk_empty;
    logic              stk_full;
    logic              ctl_live;
    logic              push_en;

    assign pc_inc    = pc_addr + ADDR_W'(1);
    assign lvl_m1    = stack_level - LVL_W'(1);
    assign stk_empty = (stack_level == '0);
    assign stk_full  = (stack_level == LVL_W'(STACK_DEPTH));

    // Control inputs only act in RUN when neither stall nor halt claims the cycle.
    assign ctl_live = (state == RUN) && !stall && !halt;
    assign push_en  = ctl_live && !is_ret && is_call && !stk_full;

    // Entries need no reset: stack_level alone defines which are live.
    always_ff @(posedge clk) begin
        if (push_en)
            stk[stack_level[PTR_W-1:0]] <= pc_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            pc_addr         <= RESET_ADDR;
            pc_valid        <= 1'b1;
            halted          <= 1'b0;
            stack_level     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            state    <= HALTED;
                            pc_valid <= 1'b0;
                            halted   <= 1'b1;
                        end else if (is_ret) begin
                            if (stk_empty) begin
                                stack_underflow <= 1'b1;
                                pc_addr         <= pc_inc;
                            end else begin
                                pc_addr     <= stk[lvl_m1[PTR_W-1:0]];
                                stack_level <= lvl_m1;
                            end
                        end else if (is_call) begin
                            if (stk_full) begin
                                stack_overflow <= 1'b1;
                                pc_addr        <= pc_inc;
                            end else begin
                                pc_addr     <= jmp_target;
                                stack_level <= stack_level + LVL_W'(1);
                            end
                        end else if (is_jmp) begin
                            pc_addr <= jmp_target;
                        end else begin
                            pc_addr <= pc_inc;
                        end
                    end
                end
                HALTED: begin
                    // pc_addr is left alone so the first fetch after resume is the held address.
                    if (resume) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prgrm_counter_stk.sv
// Directed bench for prgrm_counter_stk: queue-based reference model compared
// every cycle, plus literal expectations along the test plan.
module tb_prgrm_counter_stk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 0, is_jmp = 0, is_call = 0, is_ret = 0, halt = 0, resume = 0;
    logic [7:0] jmp_target = '0;

    logic [7:0] pc_addr;
    logic       pc_valid, halted, stack_overflow, stack_underflow;
    logic [2:0] stack_level;

    logic [7:0] pc2;
    logic       pc_valid2, halted2, of2, uf2;
    logic [2:0] lvl2;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_pc = 0;
    bit         m_halted = 0, m_of = 0, m_uf = 0;
    logic [7:0] m_stk[$];

    prgrm_counter_stk #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .is_jmp(is_jmp), .is_call(is_call),
        .is_ret(is_ret), .jmp_target(jmp_target), .halt(halt), .resume(resume),
        .pc_addr(pc_addr), .pc_valid(pc_valid), .halted(halted),
        .stack_level(stack_level), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow));

    prgrm_counter_stk #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h10)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .is_jmp(is_jmp), .is_call(is_call),
        .is_ret(is_ret), .jmp_target(jmp_target), .halt(halt), .resume(resume),
        .pc_addr(pc2), .pc_valid(pc_valid2), .halted(halted2),
        .stack_level(lvl2), .stack_overflow(of2), .stack_underflow(uf2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_halted = 0; m_of = 0; m_uf = 0;
        m_stk.delete();
    endtask

    // One clock: drive, apply the rules to the model after the edge, return at negedge.
    task automatic cyc(input bit s, input bit h, input bit r, input bit c, input bit j,
                       input logic [7:0] t, input bit rs);
        stall = s; halt = h; is_ret = r; is_call = c; is_jmp = j; jmp_target = t; resume = rs;
        @(posedge clk);
        if (!m_halted) begin
            if (s) ;
            else if (h) m_halted = 1;
            else if (r) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_uf = 1; m_pc = (m_pc + 1) % 256; end
            end else if (c) begin
                if (m_stk.size() < 4) begin m_stk.push_back(8'((m_pc + 1) % 256)); m_pc = t; end
                else begin m_of = 1; m_pc = (m_pc + 1) % 256; end
            end else if (j) m_pc = t;
            else m_pc = (m_pc + 1) % 256;
        end else if (rs) m_halted = 0;
        @(negedge clk);
        stall = 0; halt = 0; is_ret = 0; is_call = 0; is_jmp = 0; resume = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_pc",       int'(pc_addr),         m_pc);
            chk("m_valid",    int'(pc_valid),        int'(!m_halted));
            chk("m_halted",   int'(halted),          int'(m_halted));
            chk("m_level",    int'(stack_level),     m_stk.size());
            chk("m_overflow", int'(stack_overflow),  int'(m_of));
            chk("m_underflow",int'(stack_underflow), int'(m_uf));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_pc", pc_addr, 8'h00);
        chk("rst_valid", pc_valid, 1);
        chk("rst_halted", halted, 0);
        chk("rst_level", stack_level, 0);
        chk("rst_flags", {stack_overflow, stack_underflow}, 0);
        chk("rst_pc_alt", pc2, 8'h10);

        for (int i = 1; i <= 5; i++) begin
            idle(1);
            chk("inc_pc", pc_addr, i);
        end
        chk("inc_pc_alt", pc2, 8'h15);

        // call/ret nesting from pc 05
        cyc(0, 0, 0, 1, 0, 8'h20, 0); chk("call1_pc", pc_addr, 8'h20); chk("call1_lvl", stack_level, 1);
        idle(1);                      chk("run_pc", pc_addr, 8'h21);
        cyc(0, 0, 0, 1, 0, 8'h30, 0); chk("call2_pc", pc_addr, 8'h30); chk("call2_lvl", stack_level, 2);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("ret1_pc", pc_addr, 8'h22);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("ret2_pc", pc_addr, 8'h06); chk("ret2_lvl", stack_level, 0);

        // wrap, jump, stalled jump
        cyc(0, 0, 0, 0, 1, 8'hFE, 0);
        idle(1);                      chk("pre_wrap", pc_addr, 8'hFF);
        idle(1);                      chk("wrap", pc_addr, 8'h00);
        cyc(0, 0, 0, 0, 1, 8'h40, 0); chk("jmp", pc_addr, 8'h40);
        cyc(1, 0, 0, 0, 1, 8'h80, 0); chk("stall_jmp", pc_addr, 8'h40);

        // fill stack, overflow, drain, underflow
        cyc(0, 0, 0, 1, 0, 8'h10, 0);
        cyc(0, 0, 0, 1, 0, 8'h20, 0);
        cyc(0, 0, 0, 1, 0, 8'h30, 0);
        cyc(0, 0, 0, 1, 0, 8'h33, 0); chk("full_lvl", stack_level, 4);
        cyc(0, 0, 0, 1, 0, 8'h50, 0); chk("ovf_pc", pc_addr, 8'h34);
        chk("ovf_flag", stack_overflow, 1); chk("ovf_lvl", stack_level, 4);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("pop4", pc_addr, 8'h31);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("pop3", pc_addr, 8'h21);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("pop2", pc_addr, 8'h11);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("pop1", pc_addr, 8'h41);
        cyc(0, 0, 1, 0, 0, 8'h00, 0); chk("udf_pc", pc_addr, 8'h42); chk("udf_flag", stack_underflow, 1);
        idle(1);                      chk("sticky", {stack_overflow, stack_underflow}, 2'b11);

        // priority: ret over call/jmp, halt over call
        cyc(0, 0, 0, 1, 0, 8'h60, 0); chk("prio_call", pc_addr, 8'h60);
        cyc(0, 0, 1, 1, 1, 8'h70, 0); chk("prio_ret_pc", pc_addr, 8'h44); chk("prio_ret_lvl", stack_level, 0);
        cyc(0, 0, 0, 1, 0, 8'h70, 0); chk("pre_halt_lvl", stack_level, 1);
        cyc(0, 1, 0, 1, 0, 8'h77, 0); chk("halt_call_pc", pc_addr, 8'h70);
        chk("halt_call_h", halted, 1); chk("halt_call_lvl", stack_level, 1);
        cyc(0, 0, 0, 0, 0, 8'h00, 1); chk("resume_pc", pc_addr, 8'h70);
        cyc(0, 0, 0, 0, 0, 8'h00, 1); chk("resume_run", pc_addr, 8'h71);

        // halt at 12, ignore inputs for 10 cycles, resume
        cyc(0, 0, 0, 0, 1, 8'h12, 0);
        cyc(0, 1, 0, 0, 0, 8'h00, 0); chk("halt_h", halted, 1); chk("halt_v", pc_valid, 0);
        for (int i = 0; i < 10; i++) cyc(i[0], i[1], 0, 0, 1, 8'h99, 0);
        chk("halt_hold", pc_addr, 8'h12);
        cyc(0, 0, 0, 0, 0, 8'h00, 1); chk("res_pc", pc_addr, 8'h12); chk("res_v", pc_valid, 1);
        idle(1);                      chk("res_inc", pc_addr, 8'h13);
        cyc(0, 1, 0, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 0, 0, 8'h00, 1); chk("halt_res_both", halted, 0);

        // reset mid-HALTED with a live stack entry
        cyc(0, 1, 0, 0, 0, 8'h00, 0); chk("halt_again", halted, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc_addr, 8'h00);
        chk("mid_rst_lvl", stack_level, 0);
        chk("mid_rst_h", halted, 0);
        chk("mid_rst_v", pc_valid, 1);
        chk("mid_rst_flags", {stack_overflow, stack_underflow}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2);                      chk("post_rst_pc", pc_addr, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
